uart_tx_flex: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
- Compile-time configurable: data width, stop-bit count and bit period.
- Runtime-selectable parity, per frame.
- Valid/ready handshake with zero-gap back-to-back frames.
- Sits between a word source (FIFO or CPU register) and the serial TX pin, driving idle-high line level.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_tx_flex.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_flex.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter (and a future receiver):
//   uart_tx_state_t : transmitter FSM state encoding
//   uart_parity_t   : runtime parity selection (11 on the port means NONE)
//   uart_tpb()      : clocks per bit from clock frequency and baud rate
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } uart_parity_t;

    // Integer division: any fractional remainder is a baud-rate error the
    // integrator accepts by choosing CLOCK_FREQ / BAUD_RATE.
    function automatic int uart_tpb(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer: a down-counter reloaded to TPB-1 that flags the last
// clock of every bit period. Shared between transmitter and receiver.
//
// Ports
//   clock       in  : system clock, rising edge
//   resetn      in  : synchronous active-low reset (counter -> 0)
//   i_reload    in  : restart the period (counter -> TPB-1), wins over enable
//   i_enable    in  : count one clock; wraps to TPB-1 after reaching 0
//   o_tick      out : high in the last clock of a bit period (count == 0)
//   o_pre_tick  out : high one clock before o_tick (count == 1)
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int TPB = 10
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_reload,
    input  logic i_enable,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int              CW     = $clog2(TPB) + 1;
    localparam logic [CW-1:0]   RELOAD = CW'(TPB - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_reload) begin
            r_count <= RELOAD;
        end else if (i_enable) begin
            r_count <= (r_count == '0) ? RELOAD : (r_count - CW'(1));
        end
    end

    assign o_tick     = i_enable && (r_count == '0);
    assign o_pre_tick = i_enable && (r_count == CW'(1));

endmodule

// File: rtl/uart_tx_flex.sv
// ---------------------------------------------------------------------------
// uart_tx_flex
// Parametrised UART transmitter with valid/ready input and idle-high line.
// Frame: start (0), DATA_WIDTH bits LSB first, optional parity, STOP_BITS
// stop bits (1). Back-to-back frames leave no idle gap.
//
// Build option: define UART_TX_FLEX_PARITY_EN to include the PARITY state
// and per-frame parity selection. Without it parity_mode is ignored.
//
// Ports
//   clock        in  : system clock, rising edge
//   resetn       in  : synchronous active-low reset
//   data         in  : word to send, sampled on valid && ready
//   valid        in  : source has a word
//   parity_mode  in  : 00 none, 01 even, 10 odd, 11 none; sampled on handshake
//   ready        out : a word is accepted this cycle (registered)
//   busy         out : frame in progress (registered)
//   signal       out : serial TX line, idle high (registered)
//
// State   | meaning
// IDLE    | line high, ready high, waiting for valid
// START   | start bit (low) for one bit period
// DATA    | data bits, LSB first, one period each
// PARITY  | parity bit for one period (parity build only)
// STOP    | STOP_BITS periods high; ready in the final clock
// ---------------------------------------------------------------------------
module uart_tx_flex
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    input  logic [1:0]            parity_mode,
    output logic                  ready,
    output logic                  busy,
    output logic                  signal
);

    localparam int TPB = uart_tpb(CLOCK_FREQ, BAUD_RATE);
    localparam int IW  = $clog2(DATA_WIDTH) + 1;

    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef UART_TX_FLEX_PARITY_EN
    localparam logic [2:0] S_PARITY = ST_PARITY;
`endif

    if (TPB < 2) begin : g_bad_tpb
        $error("uart_tx_flex: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end
    if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9)) begin : g_bad_width
        $error("uart_tx_flex: DATA_WIDTH must be within 5..9");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_tx_flex: STOP_BITS must be 1 or 2");
    end

    logic [2:0]            r_state;
    logic                  r_signal;
    logic                  r_ready;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IW-1:0]         r_idx;      // data bit index, reused as stop-bit count
`ifdef UART_TX_FLEX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_bit;
`else
    logic                  w_unused_parity;
    assign w_unused_parity = ^parity_mode;
`endif

    logic w_xfer;
    logic w_run;
    logic w_tick;
    logic w_pre_tick;

    assign w_xfer = valid && r_ready;
    assign w_run  = (r_state != S_IDLE);

    // Reload on every accepted word so the start bit gets a full period,
    // including the zero-gap case where the previous stop period just ended.
    uart_baud_tick #(
        .TPB (TPB)
    ) u_baud_tick (
        .clock      (clock),
        .resetn     (resetn),
        .i_reload   (w_xfer),
        .i_enable   (w_run),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_signal <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_shift  <= '0;
            r_idx    <= '0;
`ifdef UART_TX_FLEX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_signal <= 1'b1;
                end

                S_START: begin
                    if (w_tick) begin
                        r_state  <= S_DATA;
                        r_signal <= r_shift[0];
                        r_idx    <= '0;
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        if (r_idx == LAST_DATA) begin
                            r_idx <= '0;
`ifdef UART_TX_FLEX_PARITY_EN
                            if (r_par_en) begin
                                r_state  <= S_PARITY;
                                r_signal <= r_par_bit;
                            end else begin
                                r_state  <= S_STOP;
                                r_signal <= 1'b1;
                            end
`else
                            r_state  <= S_STOP;
                            r_signal <= 1'b1;
`endif
                        end else begin
                            r_shift  <= r_shift >> 1;
                            r_signal <= r_shift[1];
                            r_idx    <= r_idx + IW'(1);
                        end
                    end
                end

`ifdef UART_TX_FLEX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_state  <= S_STOP;
                        r_signal <= 1'b1;
                        r_idx    <= '0;
                    end
                end
`endif

                S_STOP: begin
                    // Raise ready one clock early so it is visible, from a
                    // register, during the final clock of the last stop bit.
                    if (w_pre_tick && (r_idx == LAST_STOP)) begin
                        r_ready <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_idx == LAST_STOP) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_signal <= 1'b1;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_idx    <= '0;
                end
            endcase

            // Accepting a word overrides the end-of-stop return to IDLE,
            // which is what makes back-to-back frames gapless.
            if (w_xfer) begin
                r_state  <= S_START;
                r_signal <= 1'b0;
                r_ready  <= 1'b0;
                r_busy   <= 1'b1;
                r_shift  <= data;
                r_idx    <= '0;
`ifdef UART_TX_FLEX_PARITY_EN
                r_par_en  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                r_par_bit <= (parity_mode == PAR_ODD) ? ~(^data) : (^data);
`endif
            end
        end
    end

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign signal = r_signal;

endmodule

// File: tb/tb_uart_tx_flex.sv
module tb_uart_tx_flex;

    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int TPB = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn = 1'b0;

    logic [7:0] data8  = '0;
    logic       valid8 = 1'b0;
    logic [1:0] pm8    = '0;
    logic       ready8, busy8, sig8;

    logic [6:0] data7  = '0;
    logic       valid7 = 1'b0;
    logic [1:0] pm7    = '0;
    logic       ready7, busy7, sig7;

    uart_tx_flex #(
        .CLOCK_FREQ (CF), .BAUD_RATE (BR), .DATA_WIDTH (8), .STOP_BITS (1)
    ) dut8 (
        .clock (clock), .resetn (resetn), .data (data8), .valid (valid8),
        .parity_mode (pm8), .ready (ready8), .busy (busy8), .signal (sig8)
    );

    uart_tx_flex #(
        .CLOCK_FREQ (CF), .BAUD_RATE (BR), .DATA_WIDTH (7), .STOP_BITS (2)
    ) dut7 (
        .clock (clock), .resetn (resetn), .data (data7), .valid (valid7),
        .parity_mode (pm7), .ready (ready7), .busy (busy7), .signal (sig7)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          bw [8];
    int          bm [8];
    logic [15:0] obs_bits;
    int          obs_clocks;
    int          rdy_low;
    int          busy_hi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic get_sig(input int sel);
        return (sel != 0) ? sig7 : sig8;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel != 0) ? ready7 : ready8;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy7 : busy8;
    endfunction

    task automatic drive(input int sel, input int word, input int mode, input logic v);
        if (sel != 0) begin
            data7 = word[6:0]; pm7 = mode[1:0]; valid7 = v;
        end else begin
            data8 = word[7:0]; pm8 = mode[1:0]; valid8 = v;
        end
    endtask

    // Reference frame: list of line levels, one per bit period.
    function automatic void build_exp(input int dw, input int sb, input int word, input int mode,
                                      output logic [15:0] bits, output int nbits);
        int  n;
        int  ones;
        n     = 0;
        ones  = 0;
        bits  = '1;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < dw; i++) begin
            bits[n] = ((word >> i) & 1) != 0;
            ones += (word >> i) & 1;
            n++;
        end
`ifdef UART_TX_FLEX_PARITY_EN
        if (mode == 1) begin bits[n] = (ones % 2) == 1; n++; end
        if (mode == 2) begin bits[n] = (ones % 2) == 0; n++; end
`else
        if (mode > 3) ones = 0;
`endif
        for (int s = 0; s < sb; s++) begin
            bits[n] = 1'b1; n++;
        end
        nbits = n;
    endfunction

    // Sends bw[0..n-1] with valid held high across the burst, checking the
    // line, ready and busy every clock against the reference frames.
    task automatic run_burst(input int sel, input int n);
        logic [15:0] eb;
        int          nb;
        int          len;
        int          budget;
        obs_bits   = '0;
        obs_clocks = 0;
        rdy_low    = 0;
        busy_hi    = 0;
        @(negedge clock);
        drive(sel, bw[0], bm[0], 1'b1);
        budget = 0;
        while (get_ready(sel) !== 1'b1 && budget < 1000) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 1000) begin
            check("handshake_timeout", 32'd0, 32'd1);
            drive(sel, 0, 0, 1'b0);
            return;
        end
        @(posedge clock);
        for (int k = 0; k < n; k++) begin
            build_exp((sel != 0) ? 7 : 8, (sel != 0) ? 2 : 1, bw[k], bm[k], eb, nb);
            len = nb * TPB;
            for (int c = 0; c < len; c++) begin
                @(negedge clock);
                if (c == 0) begin
                    if (k + 1 < n) drive(sel, bw[k+1], bm[k+1], 1'b1);
                    else           drive(sel, $urandom, $urandom, 1'b0);
                end
                check("signal", {31'd0, get_sig(sel)}, {31'd0, eb[c / TPB]});
                check("busy",   {31'd0, get_busy(sel)}, 32'd1);
                check("ready",  {31'd0, get_ready(sel)}, (c == len - 1) ? 32'd1 : 32'd0);
                obs_clocks++;
                if (get_ready(sel) !== 1'b1) rdy_low++;
                if (get_busy(sel) === 1'b1)  busy_hi++;
                if (k == n - 1 && (c % TPB) == TPB / 2) obs_bits[c / TPB] = get_sig(sel);
            end
        end
        @(negedge clock);
        check("idle_signal", {31'd0, get_sig(sel)},   32'd1);
        check("idle_ready",  {31'd0, get_ready(sel)}, 32'd1);
        check("idle_busy",   {31'd0, get_busy(sel)},  32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_sig8",   {31'd0, sig8},   32'd1);
        check("rst_ready8", {31'd0, ready8}, 32'd1);
        check("rst_busy8",  {31'd0, busy8},  32'd0);
        check("rst_sig7",   {31'd0, sig7},   32'd1);
        check("rst_ready7", {31'd0, ready7}, 32'd1);
        check("rst_busy7",  {31'd0, busy7},  32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // 0xA5, no parity, 8N1
        bw[0] = 'hA5; bm[0] = 0;
        run_burst(0, 1);
        check("a5_bits",    {22'd0, obs_bits[9:0]}, 32'b1101001010);
        check("a5_clocks",  obs_clocks, 32'd100);
        check("a5_rdy_low", rdy_low,    32'd99);
        check("a5_busy_hi", busy_hi,    32'd100);

        // 0x07, even then odd parity
        bw[0] = 'h07; bm[0] = 1;
        run_burst(0, 1);
`ifdef UART_TX_FLEX_PARITY_EN
        check("even_clocks", obs_clocks, 32'd110);
        check("even_par",    {31'd0, obs_bits[9]},  32'd1);
        check("even_stop",   {31'd0, obs_bits[10]}, 32'd1);
`else
        check("even_clocks", obs_clocks, 32'd100);
        check("even_stop",   {31'd0, obs_bits[9]}, 32'd1);
`endif
        bw[0] = 'h07; bm[0] = 2;
        run_burst(0, 1);
`ifdef UART_TX_FLEX_PARITY_EN
        check("odd_clocks", obs_clocks, 32'd110);
        check("odd_par",    {31'd0, obs_bits[9]}, 32'd0);
`else
        check("odd_clocks", obs_clocks, 32'd100);
        check("odd_stop",   {31'd0, obs_bits[9]}, 32'd1);
`endif

        // Back-to-back 0x00 then 0xFF
        bw[0] = 'h00; bm[0] = 0;
        bw[1] = 'hFF; bm[1] = 0;
        run_burst(0, 2);
        check("b2b_clocks", obs_clocks, 32'd200);
        check("b2b_start2", {31'd0, obs_bits[0]}, 32'd0);

        // 7 data bits, 2 stop bits
        bw[0] = 'h55; bm[0] = 0;
        run_burst(1, 1);
        check("w7_bits",   {22'd0, obs_bits[9:0]}, 32'b1110101010);
        check("w7_clocks", obs_clocks, 32'd100);

        // Reset in the middle of a frame
        @(negedge clock);
        drive(0, 'h5A, 0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        drive(0, 0, 0, 1'b0);
        repeat (34) @(negedge clock);
        check("pre_rst_sig",  {31'd0, sig8},  32'd0);
        check("pre_rst_busy", {31'd0, busy8}, 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("mid_rst_sig",   {31'd0, sig8},   32'd1);
        check("mid_rst_ready", {31'd0, ready8}, 32'd1);
        check("mid_rst_busy",  {31'd0, busy8},  32'd0);
        bw[0] = 'h3C; bm[0] = 0;
        run_burst(0, 1);
        check("x3c_bits",   {22'd0, obs_bits[9:0]}, 32'b1001111000);
        check("x3c_clocks", obs_clocks, 32'd100);

        // Randomised bursts on both widths
        for (int i = 0; i < 12; i++) begin
            int sel;
            int n;
            sel = $urandom_range(0, 1);
            n   = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                bw[k] = $urandom_range(0, 255);
                bm[k] = $urandom_range(0, 3);
            end
            run_burst(sel, n);
            repeat ($urandom_range(0, 4)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
